led_fnd_axil_ctrl: RTL and testbench

AXI4-Lite slave peripheral driving a parametrised LED bank and an N-digit multiplexed 7-segment (FND) display. Supersedes the fixed 4-register LED/FND IP: generalised LED count, digit count, polarity, programmable scan rate, byte strobes, decode-error responses. Sits behind the PS AXI interconnect; pins go to board LEDs and FND segment/common lines.

---
 rtl/led_fnd_axil_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_led_fnd_axil_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fnd_axil_ctrl.sv
`default_nettype none
// =============================================================================
// led_fnd_axil_ctrl : AXI4-Lite LED bank + multiplexed N-digit 7-segment driver
// Optional BLINK register (0x10) is built when LED_FND_BLINK_EN is defined.
// Revision: 1.0
// =============================================================================
module led_fnd_axil_ctrl #(
   parameter int          C_S_AXI_ADDR_WIDTH = 5,
   parameter int          NUM_LEDS           = 8,
   parameter int          NUM_DIGITS         = 4,
   parameter bit          SEG_ACTIVE_LOW     = 1'b1,
   parameter bit          COM_ACTIVE_LOW     = 1'b1,
   parameter logic [15:0] SCAN_DIV_RST       = 16'd50000
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [31:0]                   S_AXI_WDATA,
   input  logic [3:0]                    S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [31:0]                   S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic [NUM_LEDS-1:0]           led,
   output logic [7:0]                    fnd_seg,
   output logic [NUM_DIGITS-1:0]         fnd_com
);

   localparam int AW    = C_S_AXI_ADDR_WIDTH;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef LED_FND_BLINK_EN
   localparam int NUM_REGS = 5;
`else
   localparam int NUM_REGS = 4;
`endif
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

   wr_state_t wr_state, wr_state_nxt;
   rd_state_t rd_state, rd_state_nxt;
   logic      wr_fire, rd_fire, bvalid, rvalid;

   logic [NUM_LEDS-1:0]     led_reg;
   logic [4*NUM_DIGITS-1:0] fnd_data;
   logic                    fnd_en;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic [15:0]             scan_div;
`ifdef LED_FND_BLINK_EN
   logic [NUM_LEDS-1:0]     blink_mask;
   logic [7:0]              blink_period;
   logic [7:0]              frame_cnt;
   logic                    blink_phase;
   logic                    frame_end;
`endif

   logic [31:0]   reg_word [8];
   logic [AW-3:0] wr_word, rd_word;
   logic [2:0]    wr_sel, rd_sel;
   logic          wr_map, rd_map, scan_wr;
   logic [31:0]   wr_merged;

   logic [15:0]             presc;
   logic [IDX_W-1:0]        dig_idx;
   logic                    adv, last_dig;
   logic [NUM_DIGITS-1:0]   com_onehot;
   logic [4*NUM_DIGITS-1:0] data_sh;
   logic [7:0]              seg_on;
   logic                    unused_ok;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h3F;
         4'h1: return 7'h06;
         4'h2: return 7'h5B;
         4'h3: return 7'h4F;
         4'h4: return 7'h66;
         4'h5: return 7'h6D;
         4'h6: return 7'h7D;
         4'h7: return 7'h07;
         4'h8: return 7'h7F;
         4'h9: return 7'h6F;
         4'hA: return 7'h77;
         4'hB: return 7'h7C;
         4'hC: return 7'h39;
         4'hD: return 7'h5E;
         4'hE: return 7'h79;
         default: return 7'h71;
      endcase
   endfunction

   function automatic logic [31:0] merge_strb(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? nw[8*b +: 8] : old[8*b +: 8];
      return res;
   endfunction

   // 32-bit bus view of every register; unimplemented bits are constant zero
   always_comb begin
      for (int i = 0; i < 8; i++) reg_word[i] = '0;
      reg_word[0] = 32'(led_reg);
      reg_word[1] = 32'(fnd_data);
      reg_word[2] = 32'({dp_mask, 7'd0, fnd_en});
      reg_word[3] = {16'd0, scan_div};
`ifdef LED_FND_BLINK_EN
      reg_word[4] = {blink_period, 24'd0} | 32'(blink_mask);
`endif
   end

   assign wr_word   = S_AXI_AWADDR[AW-1:2];
   assign rd_word   = S_AXI_ARADDR[AW-1:2];
   assign wr_sel    = wr_word[2:0];
   assign rd_sel    = rd_word[2:0];
   assign wr_map    = (wr_word < (AW-2)'(NUM_REGS));
   assign rd_map    = (rd_word < (AW-2)'(NUM_REGS));
   assign wr_merged = merge_strb(reg_word[wr_sel], S_AXI_WDATA, S_AXI_WSTRB);
   assign scan_wr   = wr_fire && wr_map && (wr_sel == 3'd3);

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         wr_state <= W_IDLE;
         rd_state <= R_IDLE;
      end else begin
         wr_state <= wr_state_nxt;
         rd_state <= rd_state_nxt;
      end
   end

   // Ready is only offered when both write channels are present together
   always_comb begin
      wr_state_nxt = wr_state;
      wr_fire      = 1'b0;
      bvalid       = 1'b0;
      case (wr_state)
         W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_ARESET) begin
            wr_fire      = 1'b1;
            wr_state_nxt = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (S_AXI_BREADY) wr_state_nxt = W_IDLE;
         end
         default: wr_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      rd_state_nxt = rd_state;
      rd_fire      = 1'b0;
      rvalid       = 1'b0;
      case (rd_state)
         R_IDLE: if (S_AXI_ARVALID && !S_AXI_ARESET) begin
            rd_fire      = 1'b1;
            rd_state_nxt = R_DATA;
         end
         R_DATA: begin
            rvalid = 1'b1;
            if (S_AXI_RREADY) rd_state_nxt = R_IDLE;
         end
         default: rd_state_nxt = R_IDLE;
      endcase
   end

   assign S_AXI_AWREADY = wr_fire;
   assign S_AXI_WREADY  = wr_fire;
   assign S_AXI_BVALID  = bvalid;
   assign S_AXI_ARREADY = rd_fire;
   assign S_AXI_RVALID  = rvalid;

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         S_AXI_BRESP  <= RESP_OKAY;
         S_AXI_RRESP  <= RESP_OKAY;
         S_AXI_RDATA  <= '0;
         led_reg      <= '0;
         fnd_data     <= '0;
         fnd_en       <= 1'b0;
         dp_mask      <= '0;
         scan_div     <= SCAN_DIV_RST;
`ifdef LED_FND_BLINK_EN
         blink_mask   <= '0;
         blink_period <= '0;
`endif
      end else begin
         if (wr_fire) begin
            S_AXI_BRESP <= wr_map ? RESP_OKAY : RESP_SLVERR;
            if (wr_map) begin
               case (wr_sel)
                  3'd0: led_reg  <= wr_merged[NUM_LEDS-1:0];
                  3'd1: fnd_data <= wr_merged[4*NUM_DIGITS-1:0];
                  3'd2: begin
                     fnd_en  <= wr_merged[0];
                     dp_mask <= wr_merged[8 +: NUM_DIGITS];
                  end
                  3'd3: scan_div <= wr_merged[15:0];
`ifdef LED_FND_BLINK_EN
                  3'd4: begin
                     blink_mask   <= wr_merged[NUM_LEDS-1:0];
                     blink_period <= wr_merged[31:24];
                  end
`endif
                  default: ;
               endcase
            end
         end
         // Captured on the same edge a concurrent write commits, so reads see the old value
         if (rd_fire) begin
            S_AXI_RDATA <= rd_map ? reg_word[rd_sel] : 32'd0;
            S_AXI_RRESP <= rd_map ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // A divider of 0 keeps the prescaler at 0, so the digit advances every cycle
   assign adv      = (presc >= scan_div);
   assign last_dig = (dig_idx == IDX_W'(NUM_DIGITS - 1));

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         presc   <= '0;
         dig_idx <= '0;
      end else if (scan_wr) begin
         presc <= '0;
      end else if (adv) begin
         presc   <= '0;
         dig_idx <= last_dig ? '0 : dig_idx + IDX_W'(1);
      end else begin
         presc <= presc + 16'd1;
      end
   end

   assign com_onehot = NUM_DIGITS'(1) << dig_idx;
   assign data_sh    = fnd_data >> {dig_idx, 2'b00};
   assign seg_on     = {dp_mask[dig_idx], hex7(data_sh[3:0])};

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET || !fnd_en) begin
         fnd_com <= {NUM_DIGITS{COM_ACTIVE_LOW}};
         fnd_seg <= {8{SEG_ACTIVE_LOW}};
      end else begin
         fnd_com <= com_onehot ^ {NUM_DIGITS{COM_ACTIVE_LOW}};
         fnd_seg <= seg_on ^ {8{SEG_ACTIVE_LOW}};
      end
   end

`ifdef LED_FND_BLINK_EN
   assign frame_end = adv && last_dig && !scan_wr;

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET || (blink_period == 8'd0)) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (frame_end) begin
         if (frame_cnt >= blink_period - 8'd1) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   assign led = led_reg & ~(blink_mask & {NUM_LEDS{~blink_phase}});
`else
   assign led = led_reg;
`endif

   assign unused_ok = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], wr_merged, data_sh};

endmodule
`default_nettype wire

// File: tb/tb_led_fnd_axil_ctrl.sv
`default_nettype none
// tb_led_fnd_axil_ctrl : randomized AXI-Lite register, scan and response checks
// against a register-map reference model (blink checks when LED_FND_BLINK_EN is defined).
module tb_led_fnd_axil_ctrl;
   localparam int NL = 8;
   localparam int ND = 4;
`ifdef LED_FND_BLINK_EN
   localparam int NREG = 5;
`else
   localparam int NREG = 4;
`endif
   localparam logic [6:0] SEG7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [4:0]    awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic [NL-1:0] led;
   logic [7:0]    fnd_seg;
   logic [ND-1:0] fnd_com;

   led_fnd_axil_ctrl dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .led(led), .fnd_seg(fnd_seg), .fnd_com(fnd_com)
   );

   int checks = 0;
   int failures = 0;
   logic [31:0] model [8];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] reg_mask(input int i);
      case (i)
         0: return (32'd1 << NL) - 32'd1;
         1: return (32'd1 << (4 * ND)) - 32'd1;
         2: return 32'h1 | (((32'd1 << ND) - 32'd1) << 8);
         3: return 32'h0000_FFFF;
         4: return (NREG > 4) ? (((32'd1 << NL) - 32'd1) | 32'hFF00_0000) : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) model[i] = 32'd0;
      model[3] = 32'd50000;
   endtask

   task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      int i;
      i = int'(a >> 2);
      if (i < NREG) begin
         for (int b = 0; b < 4; b++) if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
         model[i] = model[i] & reg_mask(i);
      end
   endtask

   // lead > 0: AW presented lead cycles before W; lead < 0: W first
   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int bdly, output logic [1:0] resp);
      int n;
      @(posedge clk); #1;
      if (lead >= 0) begin awaddr = a; awvalid = 1'b1; end
      if (lead <= 0) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      for (int k = 0; k < ((lead < 0) ? -lead : lead); k++) begin
         @(negedge clk);
         check_val("wr_ready_single_channel", {30'd0, awready, wready}, 32'd0);
         @(posedge clk); #1;
      end
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
      check_val("wr_accept_latency", n, 0);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      check_val("bvalid_next_cycle", {31'd0, bvalid}, 32'd1);
      for (int k = 0; k < bdly; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_val("bvalid_hold", {31'd0, bvalid}, 32'd1);
      end
      bready = 1'b1;
      resp = bresp;
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [4:0] a, input int rdly,
                           output logic [31:0] data, output logic [1:0] resp);
      int n;
      @(posedge clk); #1;
      araddr = a; arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!arready && n < 20) begin @(negedge clk); n++; end
      check_val("rd_accept_latency", n, 0);
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      check_val("rvalid_next_cycle", {31'd0, rvalid}, 32'd1);
      data = rdata;
      resp = rresp;
      for (int k = 0; k < rdly; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_val("rdata_hold", rdata, data);
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic wr_chk(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [1:0] r;
      axi_write(a, d, s, 0, 0, r);
      check_val("wr_resp", r, (int'(a >> 2) < NREG) ? 32'd0 : 32'd2);
      model_write(a, d, s);
   endtask

   task automatic rd_chk(input logic [4:0] a);
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(a, 0, d, r);
      check_val("rd_data", d, model[a >> 2]);
      check_val("rd_resp", r, (int'(a >> 2) < NREG) ? 32'd0 : 32'd2);
   endtask

   // Digit index must step 0..ND-1 every div+1 cycles with the matching decoded nibble
   task automatic check_scan(input int div, input logic [15:0] data, input logic [3:0] dp);
      int last_idx, last_t, idx, cnt;
      bit seen;
      logic [7:0] exp;
      last_idx = -1; last_t = 0; seen = 1'b0;
      for (int t = 0; t < 6 * (div + 1) + 4; t++) begin
         @(negedge clk);
         cnt = 0; idx = 0;
         for (int i = 0; i < ND; i++) if (fnd_com[i] == 1'b0) begin cnt++; idx = i; end
         check_val("scan_com_onehot", cnt, 1);
         exp = ~{dp[idx], SEG7[data[4*idx +: 4]]};
         check_val("scan_seg", fnd_seg, exp);
         if (idx != last_idx) begin
            if (last_idx >= 0) begin
               check_val("scan_order", idx, (last_idx + 1) % ND);
               if (seen) check_val("scan_period", t - last_t, div + 1);
               seen = 1'b1;
            end
            last_idx = idx;
            last_t = t;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, rd_old, rd_val;
      logic [4:0]  a;
      logic [3:0]  s, dp;
      logic [1:0]  r, r2;
      int          div, toggles, last_t;
      logic [NL-1:0] last_led;

      awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
      araddr = '0; arvalid = 0; rready = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_led", led, 32'd0);
      check_val("rst_fnd_com", fnd_com, 32'hF);
      check_val("rst_fnd_seg", fnd_seg, 32'hFF);
      check_val("rst_handshake", {awready, wready, bvalid, arready, rvalid}, 32'd0);
      check_val("rst_resp_data", {bresp, rresp} | rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      axi_read(5'h0C, 0, rd_val, r);
      check_val("rst_scan_div", rd_val, 32'h0000_C350);
      check_val("rst_scan_div_resp", r, 32'd0);

      wr_chk(5'h00, 32'h01, 4'hF); wr_chk(5'h04, 32'h02, 4'hF);
      wr_chk(5'h08, 32'h03, 4'hF); wr_chk(5'h0C, 32'h04, 4'hF);
      rd_chk(5'h00); rd_chk(5'h04); rd_chk(5'h08); rd_chk(5'h0C);

      wr_chk(5'h04, 32'h0, 4'hF);
      wr_chk(5'h04, 32'h0000_3A10, 4'b0010);
      axi_read(5'h04, 1, rd_val, r);
      check_val("wstrb_byte1", rd_val, 32'h0000_3A00);

      // AW well ahead of W with a slow BREADY, then W-first, then an unmapped read
      axi_write(5'h00, 32'h5A, 4'hF, 5, 4, r);
      check_val("aw_first_resp", r, 32'd0);
      model_write(5'h00, 32'h5A, 4'hF);
      axi_write(5'h00, 32'hC3, 4'h1, -3, 2, r);
      check_val("w_first_resp", r, 32'd0);
      model_write(5'h00, 32'hC3, 4'h1);
      rd_chk(5'h00);
      axi_read(5'h14, 0, rd_val, r);
      check_val("unmapped_rdata", rd_val, 32'd0);
      check_val("unmapped_rresp", r, 32'd2);

      for (int n = 0; n < 40; n++) begin
         a = 5'($urandom_range(0, 7) << 2);
         d = $urandom;
         s = 4'($urandom);
         axi_write(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)), r);
         check_val("rand_wr_resp", r, (int'(a >> 2) < NREG) ? 32'd0 : 32'd2);
         model_write(a, d, s);
         axi_read(a, int'($urandom_range(0, 2)), rd_val, r);
         check_val("rand_rd_data", rd_val, model[a >> 2]);
         check_val("rand_rd_resp", r, (int'(a >> 2) < NREG) ? 32'd0 : 32'd2);
`ifndef LED_FND_BLINK_EN
         check_val("rand_led_out", led, model[0]);
`endif
      end

      // Concurrent read and write of the same register: read sees the old value
      d = $urandom;
      rd_old = model[0];
      fork
         axi_write(5'h00, d, 4'hF, 0, 0, r);
         axi_read(5'h00, 0, rd_val, r2);
      join
      model_write(5'h00, d, 4'hF);
      check_val("concurrent_rd_old", rd_val, rd_old);
      rd_chk(5'h00);

`ifdef LED_FND_BLINK_EN
      wr_chk(5'h10, 32'h0, 4'hF);
`endif
      wr_chk(5'h0C, 32'd2, 4'hF);
      wr_chk(5'h04, 32'h0000_8421, 4'hF);
      wr_chk(5'h08, 32'h1, 4'hF);
      repeat (8) @(posedge clk);
      check_scan(2, 16'h8421, 4'h0);
      for (int n = 0; n < 3; n++) begin
         div = int'($urandom_range(0, 4));
         d = $urandom;
         dp = 4'($urandom);
         wr_chk(5'h0C, 32'(div), 4'hF);
         wr_chk(5'h04, d, 4'hF);
         wr_chk(5'h08, 32'h1 | (32'(dp) << 8), 4'hF);
         repeat (8) @(posedge clk);
         check_scan(div, d[15:0], dp);
      end

      wr_chk(5'h08, 32'h0000_0F00, 4'hF);
      repeat (3) @(posedge clk);
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         check_val("fnd_off_com", fnd_com, 32'hF);
         check_val("fnd_off_seg", fnd_seg, 32'hFF);
      end

`ifdef LED_FND_BLINK_EN
      wr_chk(5'h0C, 32'd0, 4'hF);
      wr_chk(5'h00, 32'hFF, 4'hF);
      wr_chk(5'h10, 32'h0100_000F, 4'hF);
      repeat (6) @(posedge clk);
      @(negedge clk);
      last_led = led;
      last_t = -1;
      toggles = 0;
      for (int t = 0; t < 24; t++) begin
         @(negedge clk);
         check_val("blink_value", {31'd0, (led == 8'hFF) || (led == 8'hF0)}, 32'd1);
         if (led != last_led) begin
            if (last_t >= 0) check_val("blink_period", t - last_t, 4);
            last_t = t;
            toggles++;
            last_led = led;
         end
      end
      check_val("blink_toggles", {31'd0, toggles >= 5}, 32'd1);
`endif

      // Reset while a write response is pending
      @(posedge clk); #1;
      awaddr = 5'h00; awvalid = 1'b1; wdata = 32'hA5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      check_val("pre_reset_bvalid", {31'd0, bvalid}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_val("mid_reset_bvalid", {31'd0, bvalid}, 32'd0);
      check_val("mid_reset_led", led, 32'd0);
      check_val("mid_reset_com", fnd_com, 32'hF);
      model_reset();
      rd_chk(5'h00);
      rd_chk(5'h0C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
